// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
//   Fetch stage plus IF/ID pipeline register feeding the main control decoder.
//   Owns the PC, issues fetch requests to instruction memory, latches the
//   returned word together with its PC+4, and presents the opcode field.
//   Stalls from the hazard unit hold the PC and IF/ID; a word returned while
//   stalled is parked in a one-entry hold buffer. Taken BEQ (EX) and JAL (ID)
//   redirect the PC and flush IF/ID, overriding any stall.
//
// Handshake: a fetch is in flight whenever imem_req is high; imem_ready high
//   in that cycle means imem_rdata is the word at imem_addr and is consumed on
//   the same rising edge. imem_req is low in S_HOLD and in the first cycle
//   after reset, and imem_ready/imem_rdata are ignored whenever imem_req is low.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   stall                        hold PC and IF/ID
//   branch_taken, branch_target  EX redirect (wins over jal)
//   jal, jal_target              ID redirect
//   imem_req, imem_addr          fetch request / address (== PC)
//   imem_ready, imem_rdata       fetch response
//   ifid_valid, ifid_instr       IF/ID contents (instr is 0 when invalid)
//   ifid_pc4, ifid_opcode        PC+4 of latched word, instr[31:26]
//   dbg_state                    1 when the FSM is in S_HOLD
module instr_fetch_stage #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jal,
  input  logic [PC_WIDTH-1:0] jal_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc4,
  output logic [5:0]          ifid_opcode,
  output logic                dbg_state
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_e;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc4_q, pc4_d;
  logic [31:0]         hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0] hold_pc4_q, hold_pc4_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                accept;

  // EX branch is older than the ID jal, so it wins when both fire.
  assign redirect    = branch_taken | jal;
  assign redirect_pc = (branch_taken ? branch_target : jal_target) & ALIGN_MASK;
  assign pc_plus4    = pc_q + PC_WIDTH'(4);  // wraps modulo 2^PC_WIDTH
  // A response only counts while a request is actually outstanding.
  assign accept      = (state_q == S_REQ) && req_q && imem_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;

    if (redirect) begin
      // Flush IF/ID and the hold buffer; any word returned now is dropped.
      pc_d         = redirect_pc;
      valid_d      = 1'b0;
      instr_d      = '0;
      pc4_d        = '0;
      hold_instr_d = '0;
      hold_pc4_d   = '0;
      state_d      = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            pc_d = pc_plus4;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_plus4;
              state_d      = S_HOLD;
            end else begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
            end
          end else if (!stall) begin
            // Nothing arrived: decode sees a bubble.
            valid_d = 1'b0;
            instr_d = '0;
            pc4_d   = '0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            valid_d = 1'b1;
            instr_d = hold_instr_q;
            pc4_d   = hold_pc4_q;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign ifid_valid  = valid_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_opcode = instr_q[31:26];
  assign dbg_state   = (state_q == S_HOLD);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: a table of per-cycle vectors with
// hand-computed expectations, plus sequences for async reset and PC wrap.
module tb_instr_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        stall, branch_taken, jal, imem_ready;
  logic [31:0] branch_target, jal_target;
  logic        imem_req, ifid_valid, dbg_state;
  logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc4;
  logic [5:0]  ifid_opcode;

  logic        w_req, w_valid, w_state, w_ready;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;
  logic [5:0]  w_opcode;

  // Memory model: opcode field = word index + 1, low bits = address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    op = a[7:2] + 6'd1;
    return {op, a[25:0]};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);
  always_comb w_rdata    = mem_word(w_addr);

  instr_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jal(jal), .jal_target(jal_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_opcode(ifid_opcode), .dbg_state(dbg_state)
  );

  instr_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jal(1'b0), .jal_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata),
    .ifid_valid(w_valid), .ifid_instr(w_instr), .ifid_pc4(w_pc4),
    .ifid_opcode(w_opcode), .dbg_state(w_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jl;
    logic [31:0] jl_tgt;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_hold;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back(vec_t'{0,0,0,0,0,1, 0,32'h0000_0000,32'h000,32'h004 - 32'h4,1,0}); // req rises
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h0400_0000,32'h004,32'h004,1,0}); // word@0
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h0800_0004,32'h008,32'h008,1,0}); // word@4
    vecs.push_back(vec_t'{1,0,0,0,0,1, 1,32'h0800_0004,32'h008,32'h00C,0,1}); // @8 to hold
    vecs.push_back(vec_t'{1,0,0,0,0,1, 1,32'h0800_0004,32'h008,32'h00C,0,1});
    vecs.push_back(vec_t'{1,0,0,0,0,1, 1,32'h0800_0004,32'h008,32'h00C,0,1});
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h0C00_0008,32'h00C,32'h00C,1,0}); // release
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h1000_000C,32'h010,32'h010,1,0}); // word@C
    vecs.push_back(vec_t'{1,0,0,0,0,0, 1,32'h1000_000C,32'h010,32'h010,1,0}); // no data, stalled
    vecs.push_back(vec_t'{0,0,0,0,0,0, 0,32'h0000_0000,32'h000,32'h010,1,0}); // bubble
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h1400_0010,32'h014,32'h014,1,0}); // word@10
    vecs.push_back(vec_t'{1,0,0,0,0,1, 1,32'h1400_0010,32'h014,32'h018,0,1}); // @14 to hold
    vecs.push_back(vec_t'{1,1,32'h43,0,0,1, 0,32'h0000_0000,32'h000,32'h040,1,0}); // branch in HOLD
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h4400_0040,32'h044,32'h044,1,0}); // word@40
    vecs.push_back(vec_t'{0,1,32'h100,1,32'h200,1, 0,32'h0000_0000,32'h000,32'h100,1,0}); // both
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h0400_0100,32'h104,32'h104,1,0}); // word@100
    vecs.push_back(vec_t'{1,0,0,1,32'h207,1, 0,32'h0000_0000,32'h000,32'h204,1,0}); // jal over stall
    vecs.push_back(vec_t'{0,0,0,0,0,1, 1,32'h0800_0204,32'h208,32'h208,1,0}); // word@204
  end

  // ---------------- driver / main ----------------
  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; jal = 1'b0;
    branch_target = '0; jal_target = '0;
    imem_ready = 1'b0; w_ready = 1'b0;
    #22;
    rst_n = 1'b1;

    check("rst_valid", 32'(ifid_valid), 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4",   ifid_pc4, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    foreach (vecs[i]) begin
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].br_tgt;
      jal           = vecs[i].jl;
      jal_target    = vecs[i].jl_tgt;
      imem_ready    = vecs[i].ready;
      step();
      check($sformatf("v%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
      check($sformatf("v%0d_opcode", i), 32'(ifid_opcode), 32'(vecs[i].e_instr[31:26]));
      check($sformatf("v%0d_pc4", i), ifid_pc4, vecs[i].e_pc4);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d_hold", i), 32'(dbg_state), 32'(vecs[i].e_hold));
    end

    // Async reset in the middle of S_REQ while waiting on memory.
    stall = 1'b0; branch_taken = 1'b0; jal = 1'b0; imem_ready = 1'b0;
    step();
    check("pre_rst_addr",  imem_addr, 32'h208);
    check("pre_rst_valid", 32'(ifid_valid), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr",  imem_addr, 32'h0);
    check("async_rst_req",   32'(imem_req), 32'h0);
    check("async_rst_valid", 32'(ifid_valid), 32'h0);
    check("async_rst_instr", ifid_instr, 32'h0);
    check("async_rst_state", 32'(dbg_state), 32'h0);

    // PC wrap from RESET_PC = FFFFFFFC.
    rst2_n = 1'b1;
    w_ready = 1'b1;
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_req", 32'(w_req), 32'h1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_valid", 32'(w_valid), 32'h1);
    check("wrap_instr", w_instr, 32'h03FF_FFFC);
    check("wrap_pc4",   w_pc4, 32'h0);
    check("wrap_addr",  w_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
